// File: rtl/main_ram_ctrl_if.sv
// Core-side request/response bus of the main RAM controller.
// The CPU memory stage is the master; the controller is the slave.
interface main_ram_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             req;
  logic             we;
  logic [19:0]      addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             ack;
  logic             busy;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, busy
  );
endinterface

// File: rtl/main_ram_ctrl.sv
// Main RAM controller: sequences the active-low _cs/_oe/_w strobes of the
// asynchronous SRAM with fixed setup, pulse-width and hold cycles for one
// word per request. Every RAM-side output comes straight from a flop.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | strobes high, waiting for req; accept latches addr/we/wdata
// SETUP    | _cs low only; address and data settle before any strobe
// RD_WAIT  | _cs and _oe low; cnt counts the access window down
// WR_PULSE | _cs and _w low; cnt counts the pulse width down
// WR_HOLD  | _cs low, _w released; address/data held past rising _w
// DONE     | strobes high, one-cycle ack to the core
module main_ram_ctrl #(
  parameter int WIDTH       = 8,
  parameter int READ_WAIT   = 2,
  parameter int WRITE_PULSE = 2
) (
  input  logic             clk,
  input  logic             _reset,
  main_ram_ctrl_if.slave   core,
  output logic             _ram_cs,
  output logic             _ram_oe,
  output logic             _ram_w,
  output logic [19:0]      ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    IDLE, SETUP, RD_WAIT, WR_PULSE, WR_HOLD, DONE
  } state_t;

  localparam logic [3:0] RD_LOAD = 4'(READ_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WRITE_PULSE - 1);

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       we_r;
  logic       accept;
  logic       capture;
  logic       cs_next, oe_next, w_next;

  // Next-state, counter and strobe levels; strobes are decoded from the
  // next state so they can be registered without a cycle of lag.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (core.req) begin
          state_next = SETUP;
          accept     = 1'b1;
        end
      end
      SETUP: begin
        if (we_r) begin
          state_next = WR_PULSE;
          cnt_next   = WR_LOAD;
        end else begin
          state_next = RD_WAIT;
          cnt_next   = RD_LOAD;
        end
      end
      RD_WAIT: begin
        if (cnt == 4'd0) begin
          state_next = DONE;
          capture    = 1'b1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      WR_PULSE: begin
        if (cnt == 4'd0) state_next = WR_HOLD;
        else             cnt_next   = cnt - 4'd1;
      end
      WR_HOLD: state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    cs_next = (state_next == IDLE) || (state_next == DONE);
    oe_next = (state_next != RD_WAIT);
    w_next  = (state_next != WR_PULSE);
  end

  // State, counter, registered strobes, latched request and read capture.
  always_ff @(posedge clk) begin
    if (!_reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      we_r       <= 1'b0;
      _ram_cs    <= 1'b1;
      _ram_oe    <= 1'b1;
      _ram_w     <= 1'b1;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      core.rdata <= '0;
      core.ack   <= 1'b0;
      core.busy  <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      _ram_cs   <= cs_next;
      _ram_oe   <= oe_next;
      _ram_w    <= w_next;
      core.ack  <= (state_next == DONE);
      core.busy <= (state_next != IDLE);
      if (accept) begin
        ram_addr  <= core.addr;
        ram_wdata <= core.wdata;
        we_r      <= core.we;
      end
      if (capture) core.rdata <= ram_rdata;
    end
  end

endmodule
